// File: rtl/pkt_pkg.sv
// Shared constants and state type for the A5/C3 header + payload serial link.
package pkt_pkg;
  localparam logic [7:0] HDR_TEMP  = 8'hA5;
  localparam logic [7:0] HDR_CHECK = 8'hC3;

  typedef enum logic [2:0] {IDLE, HDR, GAP, LOAD, DATA} tx_state_t;
endpackage

// File: rtl/tx_shift_reg.sv
// 8-bit MSB-first load/shift register; each bit is held for BIT_DIV enabled cycles.
module tx_shift_reg #(
  parameter int BIT_DIV = 1
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] load_data,
  output logic       ser_bit,
  output logic       last_bit
);
  localparam int            DW       = $clog2(BIT_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;

  // Counters park on the final bit until the next load, so nothing wraps.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      shift   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (load) begin
      shift   <= load_data;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (enable && !last_bit) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        shift   <= {shift[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  assign ser_bit  = shift[7];
  assign last_bit = (bit_cnt == 3'd7) && (div_cnt == DIV_LAST);
endmodule

// File: rtl/pkt_tx_50.sv
// Packet transmitter: header byte then PAYLOAD_BYTES bytes from a show-ahead FIFO,
// each byte framed by data_ena and followed by GAP_CYC idle cycles.
module pkt_tx_50
  import pkt_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4,
  parameter int BIT_DIV       = 1,
  parameter int GAP_CYC       = 2
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       pkt_type,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       rd_fifo,
  output logic       serial_data,
  output logic       data_ena,
  output logic       busy,
  output logic       stall,
  output logic       byte_sent,
  output logic       pkt_done
);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);
  localparam logic [7:0] P_LAST   = 8'(PAYLOAD_BYTES);

  tx_state_t  state;
  logic [3:0] gap_cnt;
  logic [7:0] byte_cnt;
  logic       in_byte, sh_load, sh_bit, sh_last;
  logic [7:0] sh_data;

  assign in_byte = (state == HDR) || (state == DATA);
  assign sh_load = ((state == IDLE) && tx_start) || ((state == LOAD) && !fifo_empty);
  assign sh_data = (state == IDLE) ? (pkt_type ? HDR_CHECK : HDR_TEMP) : fifo_data;

  tx_shift_reg #(.BIT_DIV(BIT_DIV)) u_shift (
    .clk_50    (clk_50),
    .reset     (reset),
    .load      (sh_load),
    .enable    (in_byte),
    .load_data (sh_data),
    .ser_bit   (sh_bit),
    .last_bit  (sh_last)
  );

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (tx_start) begin
          state    <= HDR;
          byte_cnt <= '0;
        end
        HDR, DATA: if (sh_last) begin
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= (byte_cnt == P_LAST) ? IDLE : LOAD;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        LOAD: if (!fifo_empty) begin
          byte_cnt <= byte_cnt + 8'd1;
          state    <= DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state, so async reset clears them at once.
  assign data_ena    = in_byte;
  assign serial_data = in_byte & sh_bit;
  assign byte_sent   = in_byte & sh_last;
  assign rd_fifo     = (state == LOAD) & ~fifo_empty;
  assign stall       = (state == LOAD) & fifo_empty;
  assign busy        = (state != IDLE);
  assign pkt_done    = (state == GAP) && (gap_cnt == GAP_LAST) && (byte_cnt == P_LAST);
endmodule

// File: tb/tb_pkt_tx_50.sv
// Two transmitters (BIT_DIV 1 and 3, P=2, GAP=2) on shared stimulus, each with its own
// FIFO and a slot/offset reference model; directed scenarios plus random traffic.
module tb_pkt_tx_50;
  typedef struct packed {
    logic rd, ser, ena, busy, stall, bsent, pdone;
  } outs_t;
  localparam int B_RD = 6, B_SER = 5, B_ENA = 4, B_BUSY = 3, B_STALL = 2, B_BS = 1, B_PD = 0;
  localparam int P = 2, GAPC = 2;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1, tx_start = 1'b0, pkt_type = 1'b0, push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  int         total = 0, bad = 0, cyc = 0;
  outs_t      w0 [0:99];
  outs_t      w1 [0:99];

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int BD    = (gi == 0) ? 1 : 3;
    localparam int FRAME = 8 * BD + GAPC;

    logic       rd_fifo, serial_data, data_ena, busy, stall, byte_sent, pkt_done;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic [7:0] q [$];
    outs_t      act, exp_o;

    pkt_tx_50 #(.PAYLOAD_BYTES(P), .BIT_DIV(BD), .GAP_CYC(GAPC)) u_dut (
      .clk_50(clk_50), .reset(reset), .tx_start(tx_start), .pkt_type(pkt_type),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .rd_fifo(rd_fifo),
      .serial_data(serial_data), .data_ena(data_ena), .busy(busy), .stall(stall),
      .byte_sent(byte_sent), .pkt_done(pkt_done)
    );
    assign act = {rd_fifo, serial_data, data_ena, busy, stall, byte_sent, pkt_done};

    always @(posedge clk_50) begin
      if (act.rd && q.size() > 0) void'(q.pop_front());
      if (push_en) q.push_back(push_data);
      fifo_empty <= (q.size() == 0);
      fifo_data  <= (q.size() > 0) ? q[0] : 8'h00;
    end

    // Reference: slot k (0 = header) sent over a FRAME-cycle window at offset m_off;
    // between slots a fetch cycle waits for the FIFO.
    logic       m_act = 1'b0, m_wait = 1'b0;
    logic [7:0] m_cur = 8'h00;
    int         m_k = 0, m_off = 0;

    always @(posedge clk_50 or posedge reset) begin
      if (reset) m_act <= 1'b0;
      else if (!m_act) begin
        if (tx_start) begin
          m_act <= 1'b1; m_wait <= 1'b0; m_k <= 0; m_off <= 0;
          m_cur <= pkt_type ? 8'hC3 : 8'hA5;
        end
      end else if (m_wait) begin
        if (!fifo_empty) begin
          m_cur <= fifo_data; m_k <= m_k + 1; m_off <= 0; m_wait <= 1'b0;
        end
      end else if (m_off == FRAME - 1) begin
        if (m_k == P) m_act <= 1'b0;
        else          m_wait <= 1'b1;
      end else m_off <= m_off + 1;
    end

    always_comb begin
      exp_o = '0;
      if (!reset && m_act) begin
        exp_o.busy = 1'b1;
        if (m_wait) begin
          exp_o.rd    = !fifo_empty;
          exp_o.stall = fifo_empty;
        end else if (m_off < 8 * BD) begin
          exp_o.ena   = 1'b1;
          exp_o.ser   = m_cur[7 - m_off / BD];
          exp_o.bsent = (m_off == 8 * BD - 1);
        end else begin
          exp_o.pdone = (m_off == FRAME - 1) && (m_k == P);
        end
      end
    end
  end

  task automatic cmp_cfg(input int c, input outs_t a, input outs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cfg%0d_outs cyc=%0d got=%b want=%b (rd ser ena busy stall bsent pdone)",
               c, cyc, a, e);
    end
  endtask

  always @(negedge clk_50) begin
    cmp_cfg(0, g_cfg[0].act, g_cfg[0].exp_o);
    cmp_cfg(1, g_cfg[1].act, g_cfg[1].exp_o);
  end

  task automatic lchk(input string nm, input logic [99:0] got, input logic [99:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [99:0] rng(input int lo, input int hi);
    logic [99:0] v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [99:0] byte_at(input int c0, input logic [7:0] b, input int bd);
    logic [99:0] v = '0;
    for (int j = 0; j < 8 * bd; j++) v[c0 + j] = b[7 - j / bd];
    return v;
  endfunction

  function automatic logic [99:0] col(input int cfg, input int b);
    logic [99:0] v = '0;
    for (int i = 0; i < 100; i++) v[i] = (cfg == 0) ? w0[i][b] : w1[i][b];
    return v;
  endfunction

  task automatic step();
    @(negedge clk_50);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    step(); push_en = 1'b1; push_data = b;
    step(); push_en = 1'b0;
  endtask

  task automatic start(input logic pt);
    for (int i = 0; i < 100; i++) begin w0[i] = '0; w1[i] = '0; end
    step(); pkt_type = pt; tx_start = 1'b1;
  endtask

  // Cycle c is the c-th cycle after the tx_start cycle; inputs driven in c are seen at its end.
  task automatic run(input int scen);
    for (int c = 1; c <= 90; c++) begin
      step();
      w0[c] = g_cfg[0].act;
      w1[c] = g_cfg[1].act;
      tx_start  = (scen == 1) && (c == 5 || c == 32);
      push_en   = (scen == 3) && (c == 31 || c == 33);
      push_data = (c == 31) ? 8'hFF : 8'h56;
      if (scen == 4 && c == 15) begin
        reset = 1'b1;
        #1;
        lchk("rst_async_cfg0", 100'(g_cfg[0].act), '0);
        lchk("rst_async_cfg1", 100'(g_cfg[1].act), '0);
      end
      if (scen == 4 && c == 17) reset = 1'b0;
    end
  endtask

  initial begin
    step();
    lchk("reset_state", 100'(g_cfg[0].act), '0);
    step(); reset = 1'b0;

    // Temp packet, with extra tx_start pulses at c5 and on the pkt_done cycle.
    push_byte(8'h12); push_byte(8'h34);
    start(1'b0); run(1);
    lchk("s1_ena0",   col(0, B_ENA),  rng(1, 8) | rng(12, 19) | rng(23, 30));
    lchk("s1_ser0",   col(0, B_SER),  byte_at(1, 8'hA5, 1) | byte_at(12, 8'h12, 1) | byte_at(23, 8'h34, 1));
    lchk("s1_rd0",    col(0, B_RD),   rng(11, 11) | rng(22, 22));
    lchk("s1_done0",  col(0, B_PD),   rng(32, 32));
    lchk("s1_busy0",  col(0, B_BUSY), rng(1, 32));
    lchk("s1_bsent0", col(0, B_BS),   rng(8, 8) | rng(19, 19) | rng(30, 30));
    lchk("s6_ena1",   col(1, B_ENA),  rng(1, 24) | rng(28, 51) | rng(55, 78));
    lchk("s6_bsent1", col(1, B_BS),   rng(24, 24) | rng(51, 51) | rng(78, 78));
    lchk("s6_rd1",    col(1, B_RD),   rng(27, 27) | rng(54, 54));
    lchk("s6_done1",  col(1, B_PD),   rng(80, 80));
    lchk("s6_ser1",   col(1, B_SER),  byte_at(1, 8'hA5, 3) | byte_at(28, 8'h12, 3) | byte_at(55, 8'h34, 3));

    // Check packet.
    push_byte(8'h12); push_byte(8'h34);
    start(1'b1); run(2);
    lchk("s2_ser0", col(0, B_SER), byte_at(1, 8'hC3, 1) | byte_at(12, 8'h12, 1) | byte_at(23, 8'h34, 1));
    lchk("s2_ser1", col(1, B_SER), byte_at(1, 8'hC3, 3) | byte_at(28, 8'h12, 3) | byte_at(55, 8'h34, 3));

    // Empty FIFO after the header; FF arrives in c31, 56 in c33.
    start(1'b0); run(3);
    lchk("s3_stall0", col(0, B_STALL), rng(11, 31));
    lchk("s3_rd0",    col(0, B_RD),    rng(32, 32) | rng(43, 43));
    lchk("s3_ena0",   col(0, B_ENA),   rng(1, 8) | rng(33, 40) | rng(44, 51));
    lchk("s3_ser0",   col(0, B_SER),   byte_at(1, 8'hA5, 1) | byte_at(33, 8'hFF, 1) | byte_at(44, 8'h56, 1));
    lchk("s3_stall1", col(1, B_STALL), rng(27, 31));
    lchk("s3_done1",  col(1, B_PD),    rng(85, 85));

    // Reset in the first payload byte, then a fresh packet.
    push_byte(8'h12); push_byte(8'h34);
    start(1'b0); run(4);
    lchk("s4_done0", col(0, B_PD),   '0);
    lchk("s4_done1", col(1, B_PD),   '0);
    lchk("s4_busy0", col(0, B_BUSY), rng(1, 15));
    push_byte(8'h78);
    start(1'b0); run(0);
    lchk("s4_ser0",  col(0, B_SER), byte_at(1, 8'hA5, 1) | byte_at(12, 8'h34, 1) | byte_at(23, 8'h78, 1));
    lchk("s4_done0b", col(0, B_PD), rng(32, 32));
    lchk("s4_done1b", col(1, B_PD), rng(80, 80));

    // Random traffic against the models.
    for (int i = 0; i < 3000; i++) begin
      step();
      tx_start  = ($urandom % 6) == 0;
      pkt_type  = $urandom_range(1, 0) == 1;
      push_en   = ($urandom % 10) == 0;
      push_data = 8'($urandom);
      reset     = ($urandom % 400) == 0;
    end
    reset = 1'b0; tx_start = 1'b0;
    begin
      int k = 0;
      while ((g_cfg[0].act.busy || g_cfg[1].act.busy) && k < 400) begin
        step(); push_en = 1'b1; push_data = 8'($urandom); k++;
      end
      push_en = 1'b0;
      lchk("drain_idle", {98'd0, g_cfg[1].act.busy, g_cfg[0].act.busy}, '0);
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
